// File: rtl/baud_gen.sv
// -----------------------------------------------------------------------------
// baud_gen -- programmable UART baud / oversample tick generator
//
// A prescale counter (cnt) counts sysclk cycles from 0 up to the active
// divisor (div_reg) and then wraps. Every wrap produces one oversample tick,
// so the oversample period is div_reg+1 cycles. An oversample counter
// (os_cnt) counts wraps modulo OVS and marks the bit boundary and the bit
// centre. A new divisor loaded while counting is parked in div_next and
// applied at the next wrap, so the current period is never cut short.
//
// Parameters
//   DIV_W        width of divisor and prescale counter
//   DIV_DEFAULT  divisor in use after reset
//   OVS          oversample ticks per bit (power of two, 2..256)
//
// Ports
//   sysclk    in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   en        in   count enable; low freezes every counter
//   div_in    in   new divisor value
//   div_load  in   one-cycle strobe capturing div_in
//   rx_sync   in   phase restart (RX start-bit edge)
//   os_tick   out  one-cycle pulse per oversample period
//   bit_tick  out  one-cycle pulse every OVS os_ticks
//   mid_tick  out  one-cycle pulse at the bit centre
//   baud_clk  out  level toggling on every os_tick
//   div_pend  out  a loaded divisor is waiting for the next wrap
// -----------------------------------------------------------------------------
module baud_gen #(
    parameter int DIV_W       = 16,
    parameter int DIV_DEFAULT = 163,
    parameter int OVS         = 16
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load,
    input  logic             rx_sync,
    output logic             os_tick,
    output logic             bit_tick,
    output logic             mid_tick,
    output logic             baud_clk,
    output logic             div_pend
);

    localparam int                OS_W    = $clog2(OVS);
    localparam logic [OS_W-1:0]   OS_LAST = OS_W'(OVS - 1);
    localparam logic [OS_W-1:0]   OS_MID  = OS_W'(OVS / 2 - 1);
    localparam logic [DIV_W-1:0]  DIV_RST = DIV_W'(DIV_DEFAULT);

    logic [DIV_W-1:0] cnt;
    logic [OS_W-1:0]  os_cnt;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_next;

    // Prescale wrap happens only on enabled cycles; rx_sync and the
    // disabled-load path take precedence inside the sequential block.
    logic             wrap;
    // Divisor that becomes active when the phase restarts (wrap or rx_sync):
    // a load in the same cycle beats a parked value, which beats no change.
    logic [DIV_W-1:0] div_apply;

    assign wrap = en && (cnt == div_reg);

    always_comb begin
        div_apply = div_reg;
        if (div_load) begin
            div_apply = div_in;
        end else if (div_pend) begin
            div_apply = div_next;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            os_cnt   <= '0;
            div_reg  <= DIV_RST;
            div_next <= DIV_RST;
            div_pend <= 1'b0;
            os_tick  <= 1'b0;
            bit_tick <= 1'b0;
            mid_tick <= 1'b0;
            baud_clk <= 1'b1;
        end else begin
            // Ticks are single-cycle pulses; only a wrap raises them again.
            os_tick  <= 1'b0;
            bit_tick <= 1'b0;
            mid_tick <= 1'b0;

            if (rx_sync) begin
                // Phase restart: works even while disabled, baud_clk keeps level.
                cnt      <= '0;
                os_cnt   <= '0;
                div_reg  <= div_apply;
                div_pend <= 1'b0;
                if (div_load) begin
                    div_next <= div_in;
                end
            end else if (div_load && !en) begin
                // Nothing is counting, so the divisor can take effect at once.
                cnt      <= '0;
                div_reg  <= div_in;
                div_next <= div_in;
                div_pend <= 1'b0;
            end else if (wrap) begin
                cnt      <= '0;
                os_cnt   <= os_cnt + OS_W'(1);
                os_tick  <= 1'b1;
                bit_tick <= (os_cnt == OS_LAST);
                mid_tick <= (os_cnt == OS_MID);
                baud_clk <= ~baud_clk;
                div_reg  <= div_apply;
                div_pend <= 1'b0;
                if (div_load) begin
                    div_next <= div_in;
                end
            end else if (en) begin
                cnt <= cnt + DIV_W'(1);
                if (div_load) begin
                    div_next <= div_in;
                    div_pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_baud_gen.sv
// -----------------------------------------------------------------------------
// tb_baud_gen -- scoreboard bench for baud_gen (default parameters)
//
// The stimulus process drives inputs on the falling edge, advances a
// behavioural model (a countdown to the next tick plus a tick tally) and
// queues the outputs expected after the coming rising edge. The monitor pops
// one entry per rising edge (or per asynchronous reset event) and compares.
// -----------------------------------------------------------------------------
module tb_baud_gen;

    localparam int DIV_W   = 16;
    localparam int DIV_DEF = 163;
    localparam int OVS     = 16;

    logic             sysclk = 1'b0;
    logic             reset  = 1'b0;
    logic             en     = 1'b0;
    logic [DIV_W-1:0] div_in = '0;
    logic             div_load = 1'b0;
    logic             rx_sync  = 1'b0;
    logic             os_tick, bit_tick, mid_tick, baud_clk, div_pend;

    baud_gen #(.DIV_W(DIV_W), .DIV_DEFAULT(DIV_DEF), .OVS(OVS)) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .en       (en),
        .div_in   (div_in),
        .div_load (div_load),
        .rx_sync  (rx_sync),
        .os_tick  (os_tick),
        .bit_tick (bit_tick),
        .mid_tick (mid_tick),
        .baud_clk (baud_clk),
        .div_pend (div_pend)
    );

    always #5 sysclk = ~sysclk;

    int vectors    = 0;
    int miscompares = 0;
    int cycle      = 0;

    // Expected output bundle {os_tick, bit_tick, mid_tick, baud_clk, div_pend}
    logic [4:0] exp_q[$];
    event       async_chk;

    always @(posedge sysclk) cycle <= cycle + 1;

    // ---------------- behavioural reference model -----------------
    int m_div, m_next, m_left, m_ntick;
    bit m_pend, m_baud;

    function automatic void model_reset();
        m_div   = DIV_DEF;
        m_next  = DIV_DEF;
        m_pend  = 1'b0;
        m_left  = DIV_DEF + 1;   // cycles until the next tick
        m_ntick = 0;             // ticks since the last phase restart
        m_baud  = 1'b1;
    endfunction

    function automatic logic [4:0] reset_outputs();
        return 5'b00010;
    endfunction

    function automatic logic [4:0] model_edge(input bit e, input bit ld,
                                              input int din, input bit sy);
        bit tk = 1'b0;
        if (sy) begin
            if (ld) m_div = din;
            else if (m_pend) m_div = m_next;
            m_pend  = 1'b0;
            m_left  = m_div + 1;
            m_ntick = 0;
        end else if (ld && !e) begin
            m_div  = din;
            m_pend = 1'b0;
            m_left = m_div + 1;
        end else if (e) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                tk = 1'b1;
                if (ld) m_div = din;
                else if (m_pend) m_div = m_next;
                m_pend  = 1'b0;
                m_left  = m_div + 1;
                m_ntick = m_ntick + 1;
                m_baud  = !m_baud;
            end else if (ld) begin
                m_next = din;
                m_pend = 1'b1;
            end
        end
        return {tk,
                tk && (m_ntick % OVS == 0),
                tk && (m_ntick % OVS == OVS / 2),
                m_baud, m_pend};
    endfunction

    // ---------------- stimulus helpers -----------------
    task automatic step(input bit rst, input bit e, input bit ld,
                        input int din, input bit sy);
        logic [DIV_W-1:0] d;
        @(negedge sysclk);
        d        = DIV_W'(din);
        reset    = rst;
        en       = e;
        div_load = ld;
        div_in   = d;
        rx_sync  = sy;
        if (!rst) begin
            model_reset();
            exp_q.push_back(reset_outputs());
        end else begin
            exp_q.push_back(model_edge(e, ld, int'(d), sy));
        end
    endtask

    task automatic run(input int n, input bit e);
        for (int i = 0; i < n; i++) step(1'b1, e, 1'b0, 0, 1'b0);
    endtask

    task automatic check_val(input string name, input int act, input int req);
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // ---------------- monitor -----------------
    initial begin
        logic [4:0] e;
        logic [4:0] a;
        forever begin
            @(posedge sysclk or async_chk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {os_tick, bit_tick, mid_tick, baud_clk, div_pend};
                vectors++;
                check_val("os_tick",  int'(a[4]), int'(e[4]));
                check_val("bit_tick", int'(a[3]), int'(e[3]));
                check_val("mid_tick", int'(a[2]), int'(e[2]));
                check_val("baud_clk", int'(a[1]), int'(e[1]));
                check_val("div_pend", int'(a[0]), int'(e[0]));
            end
        end
    end

    // ---------------- watchdog -----------------
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus -----------------
    initial begin
        int first;
        int din;
        model_reset();

        // Reset held, then first tick timing with defaults.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0, 1'b0);
        first = 0;
        for (int i = 1; i <= 400; i++) begin
            step(1'b1, 1'b1, 1'b0, 0, 1'b0);
            @(posedge sysclk);
            #1;
            if (os_tick && first == 0) first = i;
        end
        check_val("first_os_tick_delay", first, 164);
        $display("txn default_div: first os_tick after %0d cycles", first);

        // div=3 loaded while disabled: bit_tick every 64, mid_tick offset 32.
        step(1'b1, 1'b0, 1'b1, 3, 1'b0);
        step(1'b1, 1'b1, 1'b0, 0, 1'b1);
        run(200, 1'b1);
        $display("txn div3: 200 cycles of bit/mid ticks");

        // div=9 running, reload 4 at cnt=2.
        step(1'b1, 1'b0, 1'b1, 9, 1'b0);
        run(2, 1'b1);
        step(1'b1, 1'b1, 1'b1, 4, 1'b0);
        run(40, 1'b1);
        $display("txn reload_9_to_4: pending divisor applied at wrap");

        // rx_sync at os_cnt=7, cnt=5 with div=9.
        step(1'b1, 1'b0, 1'b1, 9, 1'b0);
        step(1'b1, 1'b1, 1'b0, 0, 1'b1);
        run(7 * 10 + 5, 1'b1);
        step(1'b1, 1'b1, 1'b0, 0, 1'b1);
        run(200, 1'b1);
        $display("txn rx_sync: phase restart mid-bit");

        // en low for 20 cycles at cnt=2, then div 0 loaded while disabled.
        step(1'b1, 1'b1, 1'b0, 0, 1'b1);
        run(2, 1'b1);
        run(20, 1'b0);
        run(30, 1'b1);
        step(1'b1, 1'b0, 1'b1, 0, 1'b0);
        run(40, 1'b1);
        $display("txn enable_hold: freeze and div=0");

        // Asynchronous reset between clock edges.
        run(5, 1'b1);
        @(negedge sysclk);
        #2;
        reset = 1'b0;
        model_reset();
        exp_q.push_back(reset_outputs());
        -> async_chk;
        step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        run(170, 1'b1);
        $display("txn async_reset: outputs at reset values, default divisor");

        // Randomized traffic with small divisors to get many ticks.
        step(1'b1, 1'b0, 1'b1, 2, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            din = int'($urandom_range(0, 12));
            step(($urandom_range(0, 499) != 0),
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 39) == 0),
                 din,
                 ($urandom_range(0, 59) == 0));
        end
        $display("txn random: 3000 cycles");

        @(posedge sysclk);
        #3;
        check_val("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/baud_gen.md
BAUD_GEN -- requirements
Module: baud_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of divisor and prescale counter.
REQ-002 SHALL have parameter DIV_DEFAULT, default 163, divisor value loaded at reset; oversample period = divisor+1 sysclk cycles.
REQ-003 SHALL have parameter OVS, default 16, oversample ticks per bit; power of two, 2..256.
REQ-004 SHALL have port sysclk  input  1  system clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset; clock is single, reset is asynchronous assert, active-low.
REQ-006 SHALL have port en  input  1  count enable; low freezes all counters.
REQ-007 SHALL have port div_in  input  DIV_W  new divisor value.
REQ-008 SHALL have port div_load  input  1  one-cycle strobe capturing div_in.
REQ-009 SHALL have port rx_sync  input  1  synchronous phase restart (RX start-bit edge).
REQ-010 SHALL have port os_tick  output  1  one-cycle pulse per oversample period.
REQ-011 SHALL have port bit_tick  output  1  one-cycle pulse every OVS os_ticks.
REQ-012 SHALL have port mid_tick  output  1  one-cycle pulse at bit centre.
REQ-013 SHALL have port baud_clk  output  1  level toggling on every os_tick event.
REQ-014 SHALL have port div_pend  output  1  high while a loaded divisor awaits application.

Function
REQ-015 SHALL keep prescale counter cnt (DIV_W bits) and oversample counter os_cnt (log2(OVS) bits); all outputs registered.
REQ-016 SHALL, when en=1 and cnt!=div_reg, increment cnt; when cnt==div_reg, set cnt<=0 (wrap event) and assert os_tick for the following cycle only.
REQ-017 SHALL, on each wrap event, increment os_cnt modulo OVS; bit_tick asserted with os_tick when os_cnt was OVS-1; mid_tick asserted with os_tick when os_cnt was OVS/2-1.
REQ-018 SHALL toggle baud_clk on each wrap event; baud_clk period = 2*(div_reg+1) cycles.
REQ-019 SHALL treat div_reg=0 as valid: os_tick high every cycle while en=1, baud_clk toggles every cycle.
REQ-020 SHALL, on div_load with en=1, store div_in into div_next and set div_pend; div_reg<=div_next and div_pend<=0 at the next wrap event.
REQ-021 SHALL, on div_load coinciding with a wrap event, load div_in directly into div_reg at that wrap; div_pend stays 0.
REQ-022 SHALL, on div_load with en=0, load div_reg<=div_in and cnt<=0 on that edge; div_pend stays 0.
REQ-023 SHALL, on a second div_load before application, overwrite div_next (last value wins).
REQ-024 SHALL, on rx_sync=1 (regardless of en), set cnt<=0, os_cnt<=0, apply any pending divisor, clear div_pend, and suppress all tick outputs that cycle; baud_clk unchanged.
REQ-025 SHALL give priority rx_sync > div_load-with-en=0 > normal counting; rx_sync with div_load uses div_in as new div_reg.
REQ-026 SHALL, while en=0 and rx_sync=0, hold cnt, os_cnt, baud_clk; os_tick, bit_tick, mid_tick driven 0.
REQ-027 SHALL, on en rising, resume counting from the held cnt with no extra or lost tick.

Reset
REQ-028 SHALL, on reset low, asynchronously set cnt=0, os_cnt=0, div_reg=DIV_DEFAULT, div_next=DIV_DEFAULT, div_pend=0, os_tick=0, bit_tick=0, mid_tick=0, baud_clk=1.
REQ-029 SHALL, after reset deasserts mid-operation, restart counting from cnt=0 on the first sysclk edge with en=1; no tick in the reset-release cycle.

Verification
REQ-030 SHALL cover: defaults, en=1 continuous -> os_tick every 164 cycles, first one 164 cycles after reset release; baud_clk 1->0 at first tick; period 328.
REQ-031 SHALL cover: OVS=16, div=3 -> os_tick every 4 cycles, bit_tick every 64, mid_tick 32 cycles offset from bit_tick (at 8th os_tick of each bit).
REQ-032 SHALL cover: div=9 running, div_load div_in=4 at cnt=2 -> div_pend=1 until wrap, next os_tick period 10, subsequent periods 5, div_pend=0.
REQ-033 SHALL cover: rx_sync pulse at os_cnt=7, cnt=5 -> no tick that cycle, next os_tick div+1 cycles later, bit_tick after 16 further os_ticks.
REQ-034 SHALL cover: en low for 20 cycles at cnt=2 -> zero ticks, baud_clk stable; en high -> next os_tick after div_reg-2+1 cycles; div_load div_in=0 with en=0 -> os_tick every cycle once en=1.
REQ-035 SHALL cover: reset asserted asynchronously mid-bit (between edges) -> all outputs at reset values immediately, div_reg back to 163.
